// File: rtl/ram_burst_reader.sv
// Read-side burst engine for a 1-cycle-latency synchronous RAM: issues sequential,
// wrapping reads and returns the words as a valid/ready stream with a last-beat marker.
module ram_burst_reader #(
  parameter int width_p = 8,
  parameter int depth_p = 512
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [$clog2(depth_p)-1:0] req_addr_i,
  input  logic [$clog2(depth_p):0]   req_len_i,
  output logic                       rd_valid_o,
  output logic [$clog2(depth_p)-1:0] rd_addr_o,
  input  logic [width_p-1:0]         rd_data_i,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic                       busy_o
);

  localparam int aw_lp = $clog2(depth_p);
  localparam int lw_lp = aw_lp + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e             state_q, state_n;
  logic [aw_lp-1:0]   addr_q, addr_n;
  logic [lw_lp-1:0]   remaining_q, remaining_n;
  logic [lw_lp-1:0]   len_q;
  logic [lw_lp-1:0]   beat_q;
  logic               pend_q;
  logic [1:0]         occ_q, occ_n;
  logic               wptr_q, rptr_q;
  logic [width_p-1:0] buf_q [2];

  logic               accept;
  logic               issue;
  logic               pop;
  logic [2:0]         committed;

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign busy_o      = (state_q != IDLE);
  assign valid_o     = (occ_q != 2'd0);
  assign data_o      = buf_q[rptr_q];
  assign last_o      = valid_o && (beat_q == len_q - lw_lp'(1));
  assign pop         = valid_o && ready_i;
  assign rd_valid_o  = issue;
  assign rd_addr_o   = addr_q;

  // Slots already spoken for (buffered + in flight); a slot freed by this
  // cycle's pop may be refilled immediately to sustain one beat per cycle.
  assign committed = {1'b0, occ_q} + {2'b0, pend_q};
  assign issue     = (state_q == ISSUE) && (remaining_q != '0) &&
                     (committed < (3'd2 + {2'b0, pop}));
  assign occ_n     = occ_q + {1'b0, pend_q} - {1'b0, pop};

  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    remaining_n = remaining_q;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          accept      = 1'b1;
          addr_n      = req_addr_i;
          remaining_n = req_len_i;
          if (req_len_i != '0) state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_n      = addr_q + aw_lp'(1);
          remaining_n = remaining_q - lw_lp'(1);
          if (remaining_q == lw_lp'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_q && (occ_n == 2'd0)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      occ_q       <= 2'd0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      remaining_q <= remaining_n;
      pend_q      <= issue;
      occ_q       <= occ_n;
      if (accept) begin
        len_q  <= req_len_i;
        beat_q <= '0;
      end else if (pop) begin
        beat_q <= beat_q + lw_lp'(1);
      end
      if (pend_q) wptr_q <= ~wptr_q;
      if (pop)    rptr_q <= ~rptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pend_q) buf_q[wptr_q] <= rd_data_i;
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader against a behavioural 1-cycle RAM holding mem[i]=i.
module tb_ram_burst_reader;

  localparam int W  = 8;
  localparam int D  = 512;
  localparam int AW = 9;
  localparam logic [5:0] PAT = 6'b100101;

  logic          clk;
  logic          reset;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr, rd_addr;
  logic [AW:0]   req_len;
  logic          rd_valid;
  logic [W-1:0]  rd_data, data;
  logic          valid, last, ready, busy;

  ram_burst_reader #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .rd_valid_o(rd_valid), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .valid_o(valid), .data_o(data), .last_o(last), .ready_i(ready),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rd_valid) rd_data <= rd_addr[W-1:0];

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  got_d[$];
  logic          got_l[$];
  logic [AW-1:0] got_a[$];
  int            beat_cyc[$];
  int            acc_cyc[$];
  int            issued, popped, cyc, first_rd, first_v;
  logic          hold_v, hold_l;
  logic [W-1:0]  hold_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    got_d.delete(); got_l.delete(); got_a.delete();
    beat_cyc.delete(); acc_cyc.delete();
    issued = 0; popped = 0; cyc = 0; first_rd = -1; first_v = -1;
    hold_v = 1'b0; hold_l = 1'b0; hold_d = '0;
  endtask

  // Called at a falling edge with inputs applied; observes one cycle.
  task automatic sample();
    #1;
    if (hold_v) begin
      check("hold_valid", 32'(valid), 1);
      check("hold_data", 32'(data), 32'(hold_d));
      check("hold_last", 32'(last), 32'(hold_l));
    end
    if (req_valid && req_ready) begin
      acc_cyc.push_back(cyc);
      check("accept_not_busy", 32'(busy), 0);
    end
    if (rd_valid) begin
      got_a.push_back(rd_addr);
      issued++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (valid && first_v < 0) first_v = cyc;
    if (valid && ready) begin
      got_d.push_back(data);
      got_l.push_back(last);
      beat_cyc.push_back(cyc);
      popped++;
    end
    check("outstanding_le2", 32'(issued - popped <= 2), 1);
    hold_v = valid && !ready;
    hold_d = data;
    hold_l = last;
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic rdy(input int i, input int mode);
    logic [5:0] p;
    p = PAT;
    return (mode == 0) ? 1'b1 : p[5 - (i % 6)];
  endfunction

  task automatic run_burst(input int a, input int n, input int mode);
    clear();
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_len   = (AW + 1)'(n);
    ready     = rdy(0, mode);
    sample();
    req_valid = 1'b0;
    for (int i = 1; i < 200; i++) begin
      if (!busy) break;
      ready = rdy(i, mode);
      sample();
    end
    check("burst_timeout", 32'(busy), 0);
  endtask

  task automatic check_beats(input int a, input int n);
    check("beat_count", got_d.size(), n);
    check("read_count", got_a.size(), n);
    for (int i = 0; i < n && i < got_d.size() && i < got_a.size(); i++) begin
      check("beat_data", 32'(got_d[i]), (a + i) % D % 256);
      check("beat_last", 32'(got_l[i]), 32'(i == n - 1));
      check("read_addr", 32'(got_a[i]), (a + i) % D);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; ready = 1'b0;
    clear();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_last", 32'(last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_req_ready_after", 32'(req_ready), 1);
    @(negedge clk);

    // Basic burst: latency, back-to-back beats, busy release
    run_burst(5, 4, 0);
    check_beats(5, 4);
    check("first_rd_cycle", first_rd, 1);
    check("first_valid_cycle", first_v, 3);
    if (beat_cyc.size() == 4) check("beat_span", beat_cyc[3] - beat_cyc[0], 3);
    check("busy_drop_cycle", cyc, 7);

    // Address wrap
    run_burst(510, 4, 0);
    check_beats(510, 4);

    // Backpressure with toggling ready
    run_burst(0, 8, 1);
    check_beats(0, 8);

    // Zero length
    run_burst(0, 0, 0);
    check("zero_ready_back", 32'(req_ready), 1);
    check("zero_cycles", cyc, 1);
    ready = 1'b1;
    sample();
    sample();
    check("zero_no_reads", issued, 0);
    check("zero_no_beats", popped, 0);

    // Reset mid-burst
    clear();
    req_valid = 1'b1; req_addr = '0; req_len = 10'd16; ready = 1'b1;
    sample();
    req_valid = 1'b0;
    for (int i = 0; i < 50 && popped < 5; i++) sample();
    check("mid_beats", popped, 5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) check("mid_data", 32'(got_d[i]), i);
    reset = 1'b1; ready = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_valid", 32'(valid), 0);
    check("mid_rd_valid", 32'(rd_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    run_burst(100, 2, 0);
    check_beats(100, 2);

    // Back-to-back requests with req_valid held high
    clear();
    req_valid = 1'b1; req_addr = '0; req_len = 10'd3; ready = 1'b1;
    sample();
    req_addr = 9'd20; req_len = 10'd2;
    for (int i = 0; i < 60; i++) begin
      if (acc_cyc.size() >= 2) req_valid = 1'b0;
      if (acc_cyc.size() >= 2 && !busy && popped >= 5) break;
      sample();
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc_cyc.size(), 2);
    check("b2b_beats", got_d.size(), 5);
    if (got_d.size() == 5) begin
      check("b2b_d0", 32'(got_d[0]), 0);
      check("b2b_d1", 32'(got_d[1]), 1);
      check("b2b_d2", 32'(got_d[2]), 2);
      check("b2b_d3", 32'(got_d[3]), 20);
      check("b2b_d4", 32'(got_d[4]), 21);
      check("b2b_l2", 32'(got_l[2]), 1);
      check("b2b_l3", 32'(got_l[3]), 0);
      check("b2b_l4", 32'(got_l[4]), 1);
      check("b2b_l0", 32'(got_l[0] | got_l[1]), 0);
    end
    if (acc_cyc.size() == 2 && beat_cyc.size() == 5) begin
      check("b2b_second_accept", acc_cyc[1], 6);
      check("b2b_after_last", 32'(acc_cyc[1] > beat_cyc[2]), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Single-clock read-side burst engine for a ram_1r1w_sync-style memory with 1-cycle registered read latency.
- Accepts a burst request (start address, length) and issues sequential RAM reads with address wrap.
- Returns the data as a valid/ready stream with a last-beat marker.
- A 2-entry output buffer plus credit-gated issue absorbs in-flight reads under backpressure, so no beat is ever dropped or duplicated.

Parameters:
- width_p, 8, data width in bits; must match the RAM.
- depth_p, 512, RAM depth in words; power of two, at least 2.

Ports:
- clk_i  input  1  single clock for the block.
- reset_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  burst request valid.
- req_ready_o  output  1  engine idle and able to accept a request.
- req_addr_i  input  $clog2(depth_p)  burst start address.
- req_len_i  input  $clog2(depth_p)+1  number of beats in the burst; 0 is legal.
- rd_valid_o  output  1  RAM read enable.
- rd_addr_o  output  $clog2(depth_p)  RAM read address.
- rd_data_i  input  width_p  RAM read data; valid in the cycle after rd_valid_o was high.
- valid_o  output  1  output beat valid.
- data_o  output  width_p  output beat data.
- last_o  output  1  final beat of the burst; qualified by valid_o.
- ready_i  input  1  downstream accepts the beat.
- busy_o  output  1  burst in progress.

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Reset, sampled at a clk_i edge:
  - state goes to IDLE; buffer is emptied; pending flag cleared; counters cleared.
  - valid_o=0, rd_valid_o=0, last_o=0, busy_o=0, rd_addr_o=0.
  - req_ready_o=0 while reset_i is high, 1 after.
  - Reset mid-burst abandons the burst; no further beats appear.
  - data_o is don't-care while valid_o=0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready_o=1.
  - Handshake when req_valid_i && req_ready_o: latch addr, remaining=req_len_i, beat counter=0.
  - Go to ISSUE if req_len_i!=0, else stay in IDLE.
  - A zero-length request produces no beats and no rd_valid_o.
- ISSUE:
  - rd_valid_o=issue; rd_addr_o=current address.
  - issue = (remaining!=0) && (occ + pend - pop) < 2.
  - occ = buffer occupancy (0..2).
  - pend = 1 if a read was issued in the previous cycle; that data is captured into the buffer at the end of this cycle.
  - pop = valid_o && ready_i.
  - ready_i is combinationally in the issue path; this is intentional and sustains 1 beat/cycle.
  - On issue: address increments modulo depth_p (wrap from depth_p-1 to 0); remaining decrements.
  - When remaining reaches 0 after an issue, go to DRAIN.
- DRAIN:
  - rd_valid_o=0.
  - Return to IDLE once pend==0 && occ==0 after that cycle's pop.
  - The last beat may be popped in the same cycle req_ready_o returns next cycle; no overlap of bursts.
- Buffer:
  - 2-entry FIFO, written with rd_data_i in the cycle after an issue.
  - valid_o = occ!=0; data_o = head entry. Simultaneous capture and pop is legal.
  - Occupancy never exceeds 2 by construction; a bench assertion checks this.
- last_o: high with the beat whose beat index equals len-1.
- busy_o: high whenever state != IDLE.
- Latency:
  - Request handshake at edge E0.
  - First rd_valid_o is visible in the cycle after E0.
  - First valid_o rises after E2: the RAM registers at E1, the buffer captures at E2.
- Throughput: 1 beat/cycle when ready_i is held high.
- Backpressure:
  - With ready_i low, at most 2 reads are outstanding/buffered; rd_valid_o then stays low.
  - Beats are held stable (valid_o, data_o, last_o) until accepted.
- Lengths above depth_p are legal; addresses wrap and words are re-read.

Test Plan:
- RAM preloaded with mem[i]=i. Request addr=5, len=4, ready_i=1 -> data_o 5,6,7,8 on consecutive cycles; first valid_o 3 edges after the handshake; last_o only on 8; busy_o drops after the final beat.
- Wrap: depth_p=512, addr=510, len=4 -> rd_addr_o 510,511,0,1; data 510,511,0,1 (values mod 256 for width_p=8).
- Backpressure: addr=0, len=8, ready_i toggling 1,0,0,1,0,1... -> all 8 beats 0..7 delivered in order, none dropped or duplicated; occ≤2 always; data_o stable while valid_o && !ready_i.
- Zero length: len=0 -> no rd_valid_o, no valid_o; req_ready_o is 1 again the next cycle.
- Reset mid-burst: addr=0, len=16; assert reset_i after 5 beats -> the next cycle has valid_o=0 and rd_valid_o=0, state IDLE; a new request addr=100, len=2 returns 100,101 cleanly.
- Back-to-back bursts: req_valid_i held high with (0,3) then (20,2) -> 0,1,2(last) then 20,21(last); the second request is accepted only after busy_o falls.
